// File: rtl/biquad_mac_seq.sv
// Five-cycle shared-multiplier MAC sequencer for one direct-form-II biquad stage.
// It drives the operand multiplexer select codes and owns the filter state, the partial sums and the output.
module biquad_mac_seq #(
    parameter int N = 24,
    parameter int F = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] muxS,
    input  logic [N-1:0] muxC,
    input  logic [N-1:0] muxZ,
    output logic [2:0]   controlS,
    output logic [1:0]   controlC,
    output logic [2:0]   controlZ,
    output logic [N-1:0] Uk,
    output logic [N-1:0] fk,
    output logic [N-1:0] fk1,
    output logic [N-1:0] fk2,
    output logic [N-1:0] acum1,
    output logic [N-1:0] acum2,
    output logic [N-1:0] acum3,
    output logic [N-1:0] yk,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    // state | meaning
    // IDLE  | waiting for start, no write
    // M1    | acum1 <= Uk    + a1*fk1
    // M2    | fk    <= acum1 + a2*fk2
    // M3    | acum2 <=         b0*fk
    // M4    | acum3 <= acum2 + b1*fk1
    // M5    | yk    <= acum3 + b2*fk2, shift fk -> fk1 -> fk2
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M1   = 3'd1;
    localparam logic [2:0] S_M2   = 3'd2;
    localparam logic [2:0] S_M3   = 3'd3;
    localparam logic [2:0] S_M4   = 3'd4;
    localparam logic [2:0] S_M5   = 3'd5;

    localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MAX = {1'b1, {(N-1){1'b0}}};

    logic [2:0]   state_q, state_d;
    logic [N-1:0] uk_q, uk_d;
    logic [N-1:0] fk_q, fk_d;
    logic [N-1:0] fk1_q, fk1_d;
    logic [N-1:0] fk2_q, fk2_d;
    logic [N-1:0] acum1_q, acum1_d;
    logic [N-1:0] acum2_q, acum2_d;
    logic [N-1:0] acum3_q, acum3_d;
    logic [N-1:0] yk_q, yk_d;
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;

    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] prod_sh;
    logic        [N-1:0]   q_sat;
    logic        [N-1:0]   r_sat;
    logic signed [N:0]     sum;
    logic                  q_ovf;
    logic                  r_ovf;

    // The scaled product fits in N bits only if its top N+1 bits are all sign copies.
    always_comb begin
        prod    = $signed(muxS) * $signed(muxC);
        prod_sh = prod >>> F;
        q_ovf   = !((&prod_sh[2*N-1:N-1]) || !(|prod_sh[2*N-1:N-1]));
        q_sat   = q_ovf ? (prod_sh[2*N-1] ? NEG_MAX : POS_MAX) : prod_sh[N-1:0];
        sum     = $signed({q_sat[N-1], q_sat}) + $signed({muxZ[N-1], muxZ});
        r_ovf   = sum[N] ^ sum[N-1];
        r_sat   = r_ovf ? (sum[N] ? NEG_MAX : POS_MAX) : sum[N-1:0];
    end

    always_comb begin
        controlS = 3'b000;
        controlC = 2'b00;
        controlZ = 3'b000;
        case (state_q)
            S_M1: begin controlS = 3'b001; controlC = 2'b01; controlZ = 3'b001; end
            S_M2: begin controlS = 3'b010; controlC = 2'b10; controlZ = 3'b011; end
            S_M3: begin controlS = 3'b011; controlC = 2'b11; controlZ = 3'b000; end
            S_M4: begin controlS = 3'b100; controlC = 2'b01; controlZ = 3'b100; end
            S_M5: begin controlS = 3'b101; controlC = 2'b10; controlZ = 3'b101; end
            default: begin controlS = 3'b000; controlC = 2'b00; controlZ = 3'b000; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        uk_d    = uk_q;
        fk_d    = fk_q;
        fk1_d   = fk1_q;
        fk2_d   = fk2_q;
        acum1_d = acum1_q;
        acum2_d = acum2_q;
        acum3_d = acum3_q;
        yk_d    = yk_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        if (state_q != S_IDLE) begin
            ovf_d = ovf_q | q_ovf | r_ovf;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    uk_d    = x_in;
                    ovf_d   = 1'b0;
                    state_d = S_M1;
                end
            end
            S_M1: begin acum1_d = r_sat; state_d = S_M2; end
            S_M2: begin fk_d    = r_sat; state_d = S_M3; end
            S_M3: begin acum2_d = r_sat; state_d = S_M4; end
            S_M4: begin acum3_d = r_sat; state_d = S_M5; end
            S_M5: begin
                yk_d    = r_sat;
                fk2_d   = fk1_q;
                fk1_d   = fk_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            uk_q    <= '0;
            fk_q    <= '0;
            fk1_q   <= '0;
            fk2_q   <= '0;
            acum1_q <= '0;
            acum2_q <= '0;
            acum3_q <= '0;
            yk_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uk_q    <= uk_d;
            fk_q    <= fk_d;
            fk1_q   <= fk1_d;
            fk2_q   <= fk2_d;
            acum1_q <= acum1_d;
            acum2_q <= acum2_d;
            acum3_q <= acum3_d;
            yk_q    <= yk_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Uk    = uk_q;
    assign fk    = fk_q;
    assign fk1   = fk1_q;
    assign fk2   = fk2_q;
    assign acum1 = acum1_q;
    assign acum2 = acum2_q;
    assign acum3 = acum3_q;
    assign yk    = yk_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_biquad_mac_seq.sv
// Bench for biquad_mac_seq: models the coefficient/state multiplexer around the DUT and
// compares every sample against an arithmetic biquad reference with saturation.
module tb_biquad_mac_seq;
    localparam int N = 24;
    localparam int F = 14;
    localparam longint MAXV = 8388607;
    localparam longint MINV = -8388608;
    localparam longint A1 = 16957;
    localparam longint A2 = -6966;
    localparam longint B0 = 1362;
    localparam longint B1 = 2724;
    localparam longint B2 = 1362;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] x_in;
    logic [N-1:0] muxS, muxC, muxZ;
    logic [2:0]   controlS;
    logic [1:0]   controlC;
    logic [2:0]   controlZ;
    logic [N-1:0] Uk, fk, fk1, fk2, acum1, acum2, acum3, yk;
    logic         busy, done, ovf;

    int total = 0;
    int bad   = 0;

    longint m_fk1, m_fk2;
    bit     m_ovf;
    longint e_uk, e_a1, e_fk, e_a2, e_a3, e_yk;

    biquad_mac_seq #(.N(N), .F(F)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in),
        .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
        .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
        .Uk(Uk), .fk(fk), .fk1(fk1), .fk2(fk2),
        .acum1(acum1), .acum2(acum2), .acum3(acum3), .yk(yk),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // External operand multiplexer with the filter coefficients baked in.
    always_comb begin
        case (controlS)
            3'b001:  muxS = 24'(A1);
            3'b010:  muxS = 24'(A2);
            3'b011:  muxS = 24'(B0);
            3'b100:  muxS = 24'(B1);
            3'b101:  muxS = 24'(B2);
            default: muxS = '0;
        endcase
        case (controlC)
            2'b01:   muxC = fk1;
            2'b10:   muxC = fk2;
            2'b11:   muxC = fk;
            default: muxC = '0;
        endcase
        case (controlZ)
            3'b001:  muxZ = Uk;
            3'b011:  muxZ = acum1;
            3'b100:  muxZ = acum2;
            3'b101:  muxZ = acum3;
            default: muxZ = '0;
        endcase
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > MAXV) begin m_ovf = 1'b1; return MAXV; end
        if (v < MINV) begin m_ovf = 1'b1; return MINV; end
        return v;
    endfunction

    function automatic longint mac(input longint s, input longint c, input longint z);
        return clampv(clampv((s * c) >>> F) + z);
    endfunction

    task automatic model_sample(input longint x);
        m_ovf = 1'b0;
        e_uk  = x;
        e_a1  = mac(A1, m_fk1, x);
        e_fk  = mac(A2, m_fk2, e_a1);
        e_a2  = mac(B0, e_fk, 0);
        e_a3  = mac(B1, m_fk1, e_a2);
        e_yk  = mac(B2, m_fk2, e_a3);
        m_fk2 = m_fk1;
        m_fk1 = e_fk;
    endtask

    function automatic logic [7:0] ctl_exp(input int i);
        case (i)
            1:       return 8'b001_01_001;
            2:       return 8'b010_10_011;
            3:       return 8'b011_11_000;
            4:       return 8'b100_01_100;
            5:       return 8'b101_10_101;
            default: return 8'b000_00_000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns in the done cycle without advancing past it.
    task automatic do_sample(input longint x, input bit inject);
        start = 1'b1;
        x_in  = 24'(x);
        model_sample(x);
        step();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("busy", longint'(busy), 1);
            chk("done_early", longint'(done), 0);
            chk("ctl", longint'({controlS, controlC, controlZ}), longint'(ctl_exp(i)));
            if (i == 1) chk("ovf_clear", longint'(ovf), 0);
            if (inject && i == 3) begin
                start = 1'b1;
                x_in  = 24'd5000;
            end
            step();
            if (inject && i == 3) start = 1'b0;
        end
        chk("done", longint'(done), 1);
        chk("busy_end", longint'(busy), 0);
        chk("ctl_idle", longint'({controlS, controlC, controlZ}), 0);
        chk("Uk", longint'($signed(Uk)), e_uk);
        chk("acum1", longint'($signed(acum1)), e_a1);
        chk("fk", longint'($signed(fk)), e_fk);
        chk("acum2", longint'($signed(acum2)), e_a2);
        chk("acum3", longint'($signed(acum3)), e_a3);
        chk("yk", longint'($signed(yk)), e_yk);
        chk("fk1", longint'($signed(fk1)), m_fk1);
        chk("fk2", longint'($signed(fk2)), m_fk2);
        chk("ovf", longint'(ovf), longint'(m_ovf));
    endtask

    initial begin
        logic [N-1:0] xr;
        longint       x;

        rst_n = 1'b0;
        start = 1'b1;
        x_in  = 24'd123;
        step();
        step();
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_ctl", longint'({controlS, controlC, controlZ}), 0);
        chk("rst_regs", longint'(|{Uk, fk, fk1, fk2, acum1, acum2, acum3, yk}), 0);
        rst_n = 1'b1;
        start = 1'b0;
        m_fk1 = 0;
        m_fk2 = 0;
        step();

        // Impulse with an ignored start during M3.
        do_sample(16384, 1'b1);
        chk("imp1_acum1", longint'($signed(acum1)), 16384);
        chk("imp1_acum2", longint'($signed(acum2)), 1362);
        chk("imp1_yk", longint'($signed(yk)), 1362);
        step();
        chk("imp1_done_once", longint'(done), 0);
        chk("imp1_no_restart", longint'(busy), 0);

        do_sample(0, 1'b0);
        chk("imp2_acum1", longint'($signed(acum1)), 16957);
        chk("imp2_acum2", longint'($signed(acum2)), 1409);
        chk("imp2_yk", longint'($signed(yk)), 4133);
        chk("imp2_fk2", longint'($signed(fk2)), 16384);
        step();

        // Back-to-back full-scale samples drive the accumulator into saturation.
        do_sample(MAXV, 1'b0);
        do_sample(MAXV, 1'b0);
        chk("sat_acum1", longint'($signed(acum1)), MAXV);
        chk("sat_ovf", longint'(ovf), 1);
        step();
        chk("sat_ovf_sticky", longint'(ovf), 1);
        do_sample(0, 1'b0);
        step();

        // Reset during M3 aborts the sample.
        start = 1'b1;
        x_in  = 24'd16384;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_fk1 = 0;
        m_fk2 = 0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", longint'(done), 0);
            chk("abort_busy", longint'(busy), 0);
            step();
        end
        chk("abort_fk1", longint'($signed(fk1)), 0);
        chk("abort_fk2", longint'($signed(fk2)), 0);
        do_sample(16384, 1'b0);
        chk("abort_imp_yk", longint'($signed(yk)), 1362);
        step();

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                xr = 24'($urandom());
                x  = longint'($signed(xr));
            end else begin
                x = longint'($urandom_range(0, 60000)) - 30000;
            end
            do_sample(x, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rnd_done_low", longint'(done), 0);
                repeat ($urandom_range(0, 2)) step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
